wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Write-back stage directly upstream of the register file: merges single-cycle ALU results
//   and variable-latency load results into one registered write port (RegWEn/rd_addr/rd_data).
//   ALU has fixed priority; load results wait in a small FIFO. A starvation counter requests an
//   ALU stall so queued loads always drain.
// PARAMETERS
//   DEPTH        4   load FIFO entries (power of 2, >=2)
//   STARVE_LIMIT 8   consecutive ALU-won cycles with FIFO non-empty before wb_stall asserts
// PORTS
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous reset, active-high
//   alu_valid  in   1   ALU result present this cycle (no backpressure)
//   alu_rd     in   5   ALU destination register
//   alu_data   in   32  ALU result
//   ld_valid   in   1   load result offered
//   ld_ready   out  1   load result accepted when ld_valid & ld_ready
//   ld_rd      in   5   load destination register
//   ld_data    in   32  load result
//   wb_stall   out  1   registered request: upstream must hold ALU (alu_valid=0) next cycle
//   fifo_count out  $clog2(DEPTH)+1  entries queued
//   ovf_err    out  1   sticky: alu_valid seen while wb_stall asserted
//   RegWEn     out  1   register-file write enable (registered)
//   rd_addr    out  5   register-file write address (registered)
//   rd_data    out  32  register-file write data (registered)
// BEHAVIOUR
//   - Reset: RegWEn=0, rd_addr=0, rd_data=0, FIFO empty, fifo_count=0, starve counter=0,
//     wb_stall=0, ovf_err=0. Reset mid-operation discards all queued loads.
//   - ld_ready = (fifo_count != DEPTH); based on count only, no pop-through on full.
//   - Load accepted with ld_rd==0: consumed, never enqueued, never written.
//   - Per cycle, output-register source priority:
//     1) alu_valid: RegWEn<=(alu_rd!=0), rd_addr<=alu_rd, rd_data<=alu_data.
//     2) else FIFO non-empty: pop head; RegWEn<=1, rd_addr/rd_data<=head.
//     3) else RegWEn<=0; rd_addr/rd_data hold.
//   - Latency: ALU 1 cycle; load enqueued at cycle N is written earliest at N+2 (see CONFIG).
//   - Push and pop same cycle: both happen, count unchanged; FIFO preserves load order.
//   - Pointers wrap mod DEPTH; fifo_count ranges 0..DEPTH.
//   - Starve counter: +1 (saturating at STARVE_LIMIT) each cycle alu_valid & FIFO non-empty;
//     cleared on any pop or when FIFO empty. wb_stall <= (next counter == STARVE_LIMIT);
//     next cycle the FIFO pops (ALU absent), counter clears, wb_stall drops.
//   - alu_valid while wb_stall=1: ALU still wins; ovf_err<=1 (cleared only by rst).
// CONFIGURATION
//   WB_FIFO_BYPASS_EN defined: when alu_valid=0, FIFO empty and a load with ld_rd!=0 is
//     accepted, it is loaded straight into the output register (1-cycle load latency) and not
//     enqueued.
//   Undefined: every accepted load (ld_rd!=0) is enqueued first (min 2-cycle load latency).
// TESTING
//   1 ALU x5=0x1234 alone -> next cycle RegWEn=1, rd_addr=5, rd_data=0x1234; then RegWEn=0.
//   2 ALU x0=0xFFFF -> RegWEn=0; load to x0 with ld_valid -> accepted, fifo_count stays 0.
//   3 Load x7=0xAA and ALU x3=0x55 same cycle -> x3 written cycle+1, x7 cycle+2
//     (bypass build: identical, ALU present so no bypass).
//   4 ALU valid every cycle, 4 loads queued -> fifo_count=4, ld_ready=0; wb_stall after 8 ALU
//     cycles; hold ALU -> loads drain in order, one per idle cycle.
//   5 Keep alu_valid high during wb_stall -> ovf_err=1 sticky, ALU result still written.
//   6 Load x9=0x77 into idle block -> written 1 cycle later with WB_FIFO_BYPASS_EN, 2 without;
//     assert rst mid-queue -> outputs and fifo_count return to 0 immediately.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges 1-cycle ALU results and queued load results into one registered
// register-file write port. Optional macro WB_FIFO_BYPASS_EN lets an idle-cycle load skip the FIFO.
module wb_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_rd,
   input  logic [31:0]                alu_data,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [4:0]                 ld_rd,
   input  logic [31:0]                ld_data,
   output logic                       wb_stall,
   output logic [$clog2(DEPTH):0]     fifo_count,
   output logic                       ovf_err,
   output logic                       RegWEn,
   output logic [4:0]                 rd_addr,
   output logic [31:0]                rd_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [4:0]    fifo_rd   [DEPTH];
   logic [31:0]   fifo_data [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] starve_next;

   logic fifo_empty;
   logic ld_fire;
   logic bypass;
   logic push;
   logic pop;

   assign fifo_empty = (fifo_count == '0);
   assign ld_ready   = (fifo_count != CW'(DEPTH));

   // Loads to x0 are accepted but dropped here, so they never occupy a slot.
   assign ld_fire = ld_valid & ld_ready & (ld_rd != 5'd0);

`ifdef WB_FIFO_BYPASS_EN
   assign bypass = ld_fire & ~alu_valid & fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign push = ld_fire & ~bypass;
   assign pop  = ~alu_valid & ~fifo_empty;

   always_comb begin
      starve_next = '0;
      if (alu_valid && !fifo_empty) begin
         if (starve_cnt == SW'(STARVE_LIMIT))
            starve_next = starve_cnt;
         else
            starve_next = starve_cnt + SW'(1);
      end
   end

   // Storage carries no reset; occupancy is tracked purely by pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_rd[wr_ptr]   <= ld_rd;
         fifo_data[wr_ptr] <= ld_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
         wb_stall   <= 1'b0;
         ovf_err    <= 1'b0;
      end else begin
         starve_cnt <= starve_next;
         wb_stall   <= (starve_next == SW'(STARVE_LIMIT));
         if (alu_valid && wb_stall)
            ovf_err <= 1'b1;
      end
   end

   // ALU always wins; the FIFO head drains only on ALU-free cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RegWEn  <= 1'b0;
         rd_addr <= '0;
         rd_data <= '0;
      end else if (alu_valid) begin
         RegWEn  <= (alu_rd != 5'd0);
         rd_addr <= alu_rd;
         rd_data <= alu_data;
      end else if (!fifo_empty) begin
         RegWEn  <= 1'b1;
         rd_addr <= fifo_rd[rd_ptr];
         rd_data <= fifo_data[rd_ptr];
      end else if (bypass) begin
         RegWEn  <= 1'b1;
         rd_addr <= ld_rd;
         rd_data <= ld_data;
      end else begin
         RegWEn  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; expected load latency follows WB_FIFO_BYPASS_EN.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        wb_stall;
   logic [2:0]  fifo_count;
   logic        ovf_err;
   logic        RegWEn;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;

   int checks = 0;
   int errors = 0;

   wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .wb_stall   (wb_stall),
      .fifo_count (fifo_count),
      .ovf_err    (ovf_err),
      .RegWEn     (RegWEn),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = adat;
      ld_valid  = lv;
      ld_rd     = lrd;
      ld_data   = ldat;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expectOut(input string tag, input logic we, input logic [4:0] a,
                            input logic [31:0] d);
      checkOutput({tag, "_we"}, 32'(RegWEn), 32'(we));
      if (we) begin
         checkOutput({tag, "_addr"}, 32'(rd_addr), 32'(a));
         checkOutput({tag, "_data"}, rd_data, d);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      #12;
      checkOutput("rst_we", 32'(RegWEn), 32'd0);
      checkOutput("rst_addr", 32'(rd_addr), 32'd0);
      checkOutput("rst_data", rd_data, 32'd0);
      checkOutput("rst_count", 32'(fifo_count), 32'd0);
      checkOutput("rst_stall", 32'(wb_stall), 32'd0);
      checkOutput("rst_ovf", 32'(ovf_err), 32'd0);
      checkOutput("rst_ready", 32'(ld_ready), 32'd1);
      rst = 1'b0;

      $display("[TB] ALU write alone");
      applyStimulus(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
      tick();
      expectOut("t1_alu", 1'b1, 5'd5, 32'h1234);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      expectOut("t1_idle", 1'b0, 5'd0, 32'd0);
      checkOutput("t1_hold_addr", 32'(rd_addr), 32'd5);
      checkOutput("t1_hold_data", rd_data, 32'h1234);

      $display("[TB] x0 destinations");
      applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
      tick();
      checkOutput("t2_alu_x0_we", 32'(RegWEn), 32'd0);
      checkOutput("t2_alu_x0_data", rd_data, 32'hFFFF);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h99);
      #1;
      checkOutput("t2_ld_x0_ready", 32'(ld_ready), 32'd1);
      tick();
      checkOutput("t2_ld_x0_count", 32'(fifo_count), 32'd0);
      checkOutput("t2_ld_x0_we", 32'(RegWEn), 32'd0);

      $display("[TB] ALU and load same cycle, then push+pop");
      applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd7, 32'hAA);
      tick();
      expectOut("t3_alu", 1'b1, 5'd3, 32'h55);
      checkOutput("t3_count1", 32'(fifo_count), 32'd1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hBB);
      tick();
      expectOut("t3_ld7", 1'b1, 5'd7, 32'hAA);
      checkOutput("t3_pushpop_count", 32'(fifo_count), 32'd1);
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      expectOut("t3_ld8", 1'b1, 5'd8, 32'hBB);
      checkOutput("t3_count0", 32'(fifo_count), 32'd0);
      tick();
      expectOut("t3_idle", 1'b0, 5'd0, 32'd0);

      $display("[TB] starvation and overflow");
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 5'(15 + i), 32'(32'hA000 + i), (i <= 4), 5'(9 + i), 32'(32'h100 + i - 1));
         tick();
         expectOut($sformatf("t4_alu%0d", i), 1'b1, 5'(15 + i), 32'(32'hA000 + i));
         checkOutput($sformatf("t4_stall%0d", i), 32'(wb_stall), 32'(i >= 9));
         checkOutput($sformatf("t4_ovf%0d", i), 32'(ovf_err), 32'(i == 10));
         if (i == 4) begin
            checkOutput("t4_full_count", 32'(fifo_count), 32'd4);
            checkOutput("t4_full_ready", 32'(ld_ready), 32'd0);
         end
      end
      checkOutput("t4_count_after_ovf", 32'(fifo_count), 32'd4);
      for (int j = 0; j < 4; j++) begin
         applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         tick();
         expectOut($sformatf("t4_drain%0d", j), 1'b1, 5'(10 + j), 32'(32'h100 + j));
         checkOutput($sformatf("t4_drain_count%0d", j), 32'(fifo_count), 32'(3 - j));
         checkOutput($sformatf("t4_drain_stall%0d", j), 32'(wb_stall), 32'd0);
         checkOutput($sformatf("t4_ovf_sticky%0d", j), 32'(ovf_err), 32'd1);
      end
      tick();
      expectOut("t4_drained", 1'b0, 5'd0, 32'd0);

      $display("[TB] idle load latency and reset mid-queue");
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h77);
      tick();
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_FIFO_BYPASS_EN
      expectOut("t6_bypass", 1'b1, 5'd9, 32'h77);
      checkOutput("t6_bypass_count", 32'(fifo_count), 32'd0);
      tick();
      expectOut("t6_after", 1'b0, 5'd0, 32'd0);
`else
      expectOut("t6_queued", 1'b0, 5'd0, 32'd0);
      checkOutput("t6_queued_count", 32'(fifo_count), 32'd1);
      tick();
      expectOut("t6_ld9", 1'b1, 5'd9, 32'h77);
      checkOutput("t6_after_count", 32'(fifo_count), 32'd0);
`endif
      applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd21, 32'h210);
      tick();
      applyStimulus(1'b1, 5'd2, 32'h22, 1'b1, 5'd22, 32'h220);
      tick();
      checkOutput("t6_mid_count", 32'(fifo_count), 32'd2);
      rst = 1'b1;
      #1;
      checkOutput("t6_rst_we", 32'(RegWEn), 32'd0);
      checkOutput("t6_rst_addr", 32'(rd_addr), 32'd0);
      checkOutput("t6_rst_data", rd_data, 32'd0);
      checkOutput("t6_rst_count", 32'(fifo_count), 32'd0);
      checkOutput("t6_rst_ovf", 32'(ovf_err), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      tick();
      expectOut("t6_discarded", 1'b0, 5'd0, 32'd0);
      checkOutput("t6_post_count", 32'(fifo_count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
